// File: rtl/uart_tx_drain.sv
// Drains a buffer over a UART line: each valid entry becomes one start/data/stop
// frame; the first invalid entry ends the transfer early, and a full drain pulses clr_o.
module uart_tx_drain #(
    parameter int BUFFER_DEPTH = 256,
    parameter int BUFFER_WIDTH = 8,
    parameter int ADDR_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH:0]   len_i,
    output logic [ADDR_WIDTH:0]   raddr_o,
    input  logic [BUFFER_WIDTH:0] rdata_i,
    output logic                  tx_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  clr_o,
    output logic [ADDR_WIDTH:0]   count_o
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W = (BUFFER_WIDTH > 1) ? $clog2(BUFFER_WIDTH) : 1;

    localparam logic [ADDR_WIDTH:0] DEPTH_LIMIT = (ADDR_WIDTH + 1)'(BUFFER_DEPTH);
    localparam logic [ADDR_WIDTH:0] IDX_ONE     = (ADDR_WIDTH + 1)'(1);
    localparam logic [CNT_W-1:0]    CNT_LAST    = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]    CNT_ONE     = CNT_W'(1);
    localparam logic [BIT_W-1:0]    BIT_LAST    = BIT_W'(BUFFER_WIDTH - 1);
    localparam logic [BIT_W-1:0]    BIT_ONE     = BIT_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        START,
        DATA,
        STOP,
        DONE
    } state_t;

    state_t                  state_q, state_n;
    logic [ADDR_WIDTH:0]     index_q, index_n;
    logic [ADDR_WIDTH:0]     len_q, len_n;
    logic [ADDR_WIDTH:0]     count_q, count_n;
    logic [BUFFER_WIDTH-1:0] shift_q, shift_n;
    logic [CNT_W-1:0]        clk_cnt_q, clk_cnt_n;
    logic [BIT_W-1:0]        bit_cnt_q, bit_cnt_n;
    logic                    tx_q, tx_n;
    logic                    busy_q, busy_n;
    logic                    done_q, done_n;
    logic                    clr_q, clr_n;

    // Outputs are flops loaded from the next-state values, so each output is
    // already valid in the first cycle of the state it belongs to.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            index_q   <= '0;
            len_q     <= '0;
            count_q   <= '0;
            shift_q   <= '0;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            clr_q     <= 1'b0;
        end else begin
            state_q   <= state_n;
            index_q   <= index_n;
            len_q     <= len_n;
            count_q   <= count_n;
            shift_q   <= shift_n;
            clk_cnt_q <= clk_cnt_n;
            bit_cnt_q <= bit_cnt_n;
            tx_q      <= tx_n;
            busy_q    <= busy_n;
            done_q    <= done_n;
            clr_q     <= clr_n;
        end
    end

    always_comb begin
        state_n   = state_q;
        index_n   = index_q;
        len_n     = len_q;
        count_n   = count_q;
        shift_n   = shift_q;
        clk_cnt_n = clk_cnt_q;
        bit_cnt_n = bit_cnt_q;

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    index_n   = '0;
                    count_n   = '0;
                    len_n     = (len_i > DEPTH_LIMIT) ? DEPTH_LIMIT : len_i;
                    clk_cnt_n = '0;
                    bit_cnt_n = '0;
                    state_n   = (len_n == '0) ? DONE : FETCH;
                end
            end

            FETCH: begin
                clk_cnt_n = '0;
                bit_cnt_n = '0;
                if (rdata_i[0]) begin
                    shift_n = rdata_i[BUFFER_WIDTH:1];
                    state_n = START;
                end else begin
                    state_n = DONE;
                end
            end

            START: begin
                if (clk_cnt_q == CNT_LAST) begin
                    clk_cnt_n = '0;
                    state_n   = DATA;
                end else begin
                    clk_cnt_n = clk_cnt_q + CNT_ONE;
                end
            end

            // The line always carries shift_q[0]; shifting at each bit boundary
            // presents the next data bit LSB first.
            DATA: begin
                if (clk_cnt_q == CNT_LAST) begin
                    clk_cnt_n = '0;
                    if (bit_cnt_q == BIT_LAST) begin
                        state_n = STOP;
                    end else begin
                        bit_cnt_n = bit_cnt_q + BIT_ONE;
                        shift_n   = shift_q >> 1;
                    end
                end else begin
                    clk_cnt_n = clk_cnt_q + CNT_ONE;
                end
            end

            STOP: begin
                if (clk_cnt_q == CNT_LAST) begin
                    clk_cnt_n = '0;
                    count_n   = count_q + IDX_ONE;
                    index_n   = index_q + IDX_ONE;
                    state_n   = (index_n == len_q) ? DONE : FETCH;
                end else begin
                    clk_cnt_n = clk_cnt_q + CNT_ONE;
                end
            end

            DONE: begin
                state_n = IDLE;
            end

            default: begin
                state_n = IDLE;
            end
        endcase

        tx_n = 1'b1;
        if (state_n == START) begin
            tx_n = 1'b0;
        end else if (state_n == DATA) begin
            tx_n = shift_n[0];
        end

        // A clear is only safe when every requested entry actually went out.
        busy_n = (state_n != IDLE);
        done_n = (state_n == DONE);
        clr_n  = done_n && (count_n == len_n) && (len_n != '0);
    end

    assign raddr_o = index_q;
    assign count_o = count_q;
    assign tx_o    = tx_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign clr_o   = clr_q;

endmodule
